program_loader: RTL and testbench

- Writable replacement for the TD4 program ROM; sits on the CPU fetch bus and responds to instruction address A with data D.
- Adds a valid/ready byte-stream load port so a host or testbench can stream a new 16-byte program.
- While loading, holds the CPU in clear through its own CLR output. On completion it releases the CPU so execution restarts at address 0.

---
 rtl/td4_pkg.sv | 14 +
 rtl/program_ram.sv | 33 +++
 rtl/program_loader.sv | 110 +++++++++++
 tb/tb_program_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// Shared types and defaults for the TD4 writable program store.
package td4_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam logic [DATA_WIDTH-1:0] MEM_RESET_WORD = 8'h00;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/program_ram.sv
// Register-array program store: asynchronous read, synchronous write, async clear to zero.
module program_ram
    import td4_pkg::*;
#(
    parameter int ADDR_WIDTH = td4_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = td4_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_WIDTH'(MEM_RESET_WORD);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Writable TD4 program store with a byte-stream load port that holds the CPU in clear while loading.
//
// state   | meaning
// RUN     | CPU executing from the store; CPU clear released
// LOAD    | accepting bytes into consecutive addresses; CPU held in clear
// RELEASE | one-cycle DONE pulse, CPU still in clear; always returns to RUN
module program_loader
    import td4_pkg::*;
#(
    parameter int ADDR_WIDTH = td4_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = td4_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] a_i,
    output logic [DATA_WIDTH-1:0] d_o,
    input  logic                  load_start_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    output logic [ADDR_WIDTH-1:0] load_ptr_o,
    output logic                  cpu_clr_o,
    output logic                  loading_o,
    output logic                  done_o
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  ready_q;
    logic                  loading_q;
    logic                  done_q;
    logic                  cpu_clr_q;
    logic                  we;
    logic                  last_beat;

    // A restart request in LOAD takes precedence over a byte offered in the same cycle.
    assign we        = (state_q == LOAD) && load_valid_i && !load_start_i;
    assign last_beat = (ptr_q == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= RUN;
            ptr_q     <= '0;
            ready_q   <= 1'b0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            cpu_clr_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (load_start_i) begin
                        state_q   <= LOAD;
                        ptr_q     <= '0;
                        ready_q   <= 1'b1;
                        loading_q <= 1'b1;
                        cpu_clr_q <= 1'b0;
                    end else begin
                        cpu_clr_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start_i) begin
                        ptr_q <= '0;
                    end else if (load_valid_i) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (last_beat) begin
                            state_q   <= RELEASE;
                            ready_q   <= 1'b0;
                            loading_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state_q   <= RUN;
                    done_q    <= 1'b0;
                    cpu_clr_q <= 1'b1;
                end
                default: begin
                    state_q   <= RUN;
                    ptr_q     <= '0;
                    ready_q   <= 1'b0;
                    loading_q <= 1'b0;
                    done_q    <= 1'b0;
                    cpu_clr_q <= 1'b0;
                end
            endcase
        end
    end

    program_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (we),
        .waddr_i (ptr_q),
        .wdata_i (load_data_i),
        .raddr_i (a_i),
        .rdata_o (d_o)
    );

    assign load_ready_o = ready_q;
    assign load_ptr_o   = ptr_q;
    assign cpu_clr_o    = cpu_clr_q;
    assign loading_o    = loading_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized checks of program_loader against a behavioural load-protocol model.
module tb_program_loader;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [3:0] a_i;
    logic [7:0] d_o;
    logic       load_start_i;
    logic [7:0] load_data_i;
    logic       load_valid_i;
    logic       load_ready_o;
    logic [3:0] load_ptr_o;
    logic       cpu_clr_o;
    logic       loading_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;

    // Model: program image, write pointer, and which phase of the load protocol we are in.
    logic [7:0] m_mem [16];
    int         m_ptr;
    bit         m_loading;
    bit         m_releasing;
    bit         m_cpu_clr;

    int n_done;
    int n_clr_low;
    int n_ready;
    int accepted;

    program_loader dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .a_i          (a_i),
        .d_o          (d_o),
        .load_start_i (load_start_i),
        .load_data_i  (load_data_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_ptr_o   (load_ptr_o),
        .cpu_clr_o    (cpu_clr_o),
        .loading_o    (loading_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_ptr       = 0;
        m_loading   = 0;
        m_releasing = 0;
        m_cpu_clr   = 0;
    endtask

    task automatic check_outputs();
        chk("load_ready", {31'd0, load_ready_o}, {31'd0, m_loading});
        chk("loading",    {31'd0, loading_o},    {31'd0, m_loading});
        chk("done",       {31'd0, done_o},       {31'd0, m_releasing});
        chk("cpu_clr",    {31'd0, cpu_clr_o},    {31'd0, m_cpu_clr});
        chk("load_ptr",   {28'd0, load_ptr_o},   m_ptr);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            a_i = 4'(i);
            #1;
            chk(tag, {24'd0, d_o}, {24'd0, m_mem[i]});
        end
    endtask

    // One clock with the given load-port inputs; model advances on the edge, then outputs are checked.
    task automatic step(input logic st, input logic vl, input logic [7:0] dt);
        load_start_i = st;
        load_valid_i = vl;
        load_data_i  = dt;
        @(posedge clk_i);
        if (m_loading) begin
            if (st) begin
                m_ptr = 0;
            end else if (vl) begin
                m_mem[m_ptr] = dt;
                accepted++;
                if (m_ptr == 15) begin
                    m_ptr       = 0;
                    m_loading   = 0;
                    m_releasing = 1;
                end else begin
                    m_ptr++;
                end
            end
        end else if (m_releasing) begin
            m_releasing = 0;
            m_cpu_clr   = 1;
        end else if (st) begin
            m_loading = 1;
            m_ptr     = 0;
            m_cpu_clr = 0;
        end else begin
            m_cpu_clr = 1;
        end
        #1;
        if (done_o) n_done++;
        if (!cpu_clr_o) n_clr_low++;
        if (load_ready_o) n_ready++;
        check_outputs();
        a_i = 4'($urandom_range(0, 15));
        #1;
        chk("d_rand", {24'd0, d_o}, {24'd0, m_mem[a_i]});
    endtask

    task automatic clear_tallies();
        n_done    = 0;
        n_clr_low = 0;
        n_ready   = 0;
        accepted  = 0;
    endtask

    initial begin
        rst_n_i      = 1'b0;
        a_i          = '0;
        load_start_i = 1'b0;
        load_valid_i = 1'b0;
        load_data_i  = '0;
        model_reset();
        clear_tallies();

        // Reset: every word reads zero, CPU held in clear, loader idle.
        #2;
        check_outputs();
        sweep("reset_mem");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        chk("clr_after_reset", {31'd0, cpu_clr_o}, 32'd1);
        step(1'b0, 1'b0, 8'h00);

        // Full load, valid held high, first byte B3 and the rest zero.
        clear_tallies();
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, (i == 0) ? 8'hB3 : 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("full_done_cnt",  n_done,    32'd1);
        chk("full_clr_low",   n_clr_low, 32'd17);
        chk("full_ready_cyc", n_ready,   32'd16);
        a_i = 4'd0;
        #1;
        chk("full_d0", {24'd0, d_o}, 32'hB3);

        // Valid toggled every other cycle; pointer moves only on accepted beats.
        clear_tallies();
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 40 && m_loading; n++) begin
            step(1'b0, n[0], 8'h10 + 8'(accepted));
        end
        chk("alt_accepted", accepted, 32'd16);
        chk("alt_done_cnt", n_done, 32'd1);
        step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            a_i = 4'(i);
            #1;
            chk("alt_readback", {24'd0, d_o}, 32'h10 + 32'(i));
        end

        // Restart after 5 bytes; the byte offered with the restart must be dropped.
        clear_tallies();
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 8'hED)));
        step(1'b1, 1'b1, 8'hEE);
        chk("restart_ptr", {28'd0, load_ptr_o}, 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 8'hED)));
        step(1'b0, 1'b0, 8'h00);
        chk("restart_done_cnt", n_done, 32'd1);
        sweep("restart_mem");
        for (int i = 0; i < 16; i++) begin
            a_i = 4'(i);
            #1;
            chk("restart_no_ee", {31'd0, (d_o == 8'hEE)}, 32'd0);
        end

        // Reset after 8 accepted bytes discards the partial program.
        clear_tallies();
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h80 + 8'(i));
        #1;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        sweep("midload_mem");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h55);
        chk("midload_done_cnt", n_done, 32'd0);

        // LOAD_START held high through RELEASE: ignored there, honoured in the following RUN cycle.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'($urandom));
        chk("held_in_release", {31'd0, done_o}, 32'd1);
        step(1'b1, 1'b1, 8'h77);
        chk("held_run_state", {31'd0, loading_o}, 32'd0);
        step(1'b1, 1'b1, 8'h77);
        chk("held_new_load", {31'd0, loading_o}, 32'd1);

        // Randomized traffic: occasional restarts, random valid and data.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) == 0), 1'($urandom), 8'($urandom));
        end
        sweep("rand_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
